inst_queue: RTL
===============

# inst_queue

Instruction buffer between instruction fetch and the ID stage decoder. It absorbs fetch responses while decode is stalled and presents one instruction per cycle to the decoder with its PC and fetch-exception tag. It decouples the fetch and decode handshakes and clears in one cycle on a pipeline flush (branch redirect, exception, ERET).

## Interface

Parameters
- DEPTH, 4, number of entries; power of two, at least 2.

Ports
- clk  in  1  pipeline clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- flush  in  1  drop all stored entries and any enqueue this cycle.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  queue accepts an instruction; registered, equal to not-full.
- if_pc  in  32  PC of the fetched instruction.
- if_ins  in  32  fetched instruction word.
- if_adel  in  1  fetch address error on this PC.
- id_valid  out  1  head entry valid for decode.
- id_ready  in  1  ID stage consumes the head this cycle.
- id_pc  out  32  PC of the head entry.
- id_ins  out  32  instruction word of the head entry, sent to the decoder `ins`.
- id_adel  out  1  fetch address error tag of the head entry.
- level  out  $clog2(DEPTH)+1  current occupancy.

## Operation

- Storage: DEPTH entries of {pc, ins, adel}. Read and write pointers are $clog2(DEPTH)+1 bits wide and include a wrap bit. Empty means pointers are equal. Full means the index bits are equal and the wrap bits differ.
- Enqueue when if_valid && if_ready && !flush. The entry is written at wptr and wptr increments.
- Enqueue with if_adel=1 stores ins as 32'h0000_0000, a NOP, so the decoder sees a legal instruction. The adel bit travels with the entry.
- Dequeue when id_valid && id_ready. rptr increments.
- Simultaneous enqueue and dequeue: both pointers advance and level does not change. This is legal in any non-full, non-empty state.
- When full, if_ready=0 even if a dequeue occurs in the same cycle. Ready is not combinationally bypassed. The slot reopens on the next cycle.
- flush has priority over everything else:
  - id_valid is forced to 0 combinationally in the flush cycle, so no dequeue occurs.
  - The enqueue in that cycle is dropped.
  - On the next edge rptr is set to wptr, making the queue empty, and level becomes 0.
  - Delay-slot preservation is the responsibility of the flush source, which asserts flush only after the delay slot has left the queue.
- Output when empty or flushing:
  - id_valid=0.
  - id_ins=0 (NOP).
  - id_pc=0.
  - id_adel=0.
- Output when not empty: id_* are driven combinationally from the entry at rptr.
- level = wptr - rptr, computed modulo 2^(ptr width).
- Pointer wrap-around is natural binary overflow. No special case is needed.

## Timing

- Reset, whether asserted mid-operation or at power-up:
  - Pointers are cleared and all entries are invalidated.
  - Outputs go low immediately: if_ready=0, id_valid=0, id_ins=0, id_pc=0, id_adel=0, level=0.
- First cycle after resetn deasserts: if_ready=1.
- Latency: an instruction enqueued at edge N appears at id_* in the cycle after edge N. There is no fetch-to-decode bypass.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- if_ready is a function of registered state only. id_valid depends on registered state and flush.

## Structure

- Shared package holds:
  - typedef iq_entry_t {logic [31:0] pc; logic [31:0] ins; logic adel;}.
  - Constant INS_NOP = 32'h0.
- The package is shared with the decoder stage and the ID/EX register.
- Flat module with no sub-module. Storage is a register array, not a RAM macro, so that it resets asynchronously.

## Test plan

- Reset, fill, drain:
  - After reset, if_ready=1, level=0, id_valid=0.
  - With id_ready=0, enqueue PCs 0xBFC00000, +4, +8, +C. Then level=4 and if_ready=0.
  - A fifth if_valid is ignored.
  - Then id_ready=1: outputs appear in order, one per cycle, and level falls 4→0.
- Streaming: if_valid=1 and id_ready=1 held for 20 cycles. Each instruction appears exactly 1 cycle after its enqueue, level stays at 1, and pointers wrap at least twice with no loss or duplication.
- Full plus dequeue: at level=4, assert id_ready=1 and if_valid=1 in the same cycle. The dequeue happens, the enqueue is refused (if_ready=0), and on the next cycle level=3 and if_ready=1.
- Flush:
  - At level=3, flush=1 together with if_valid=1 and id_ready=1. In that cycle id_valid=0.
  - Next cycle: level=0 and id_ins=0.
  - An instruction enqueued in the cycle after the flush appears in the cycle after that.
- Address error: enqueue pc=0xBFC00001, ins=0x24020001, adel=1. The output shows id_pc=0xBFC00001, id_ins=0, id_adel=1.
- Asynchronous reset mid-stream: drop resetn at a non-edge time while level=2. Outputs clear immediately without waiting for clk. After release the queue behaves as freshly reset.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: queue entry type and NOP constant shared by fetch-queue, decoder and ID/EX register
package inst_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        adel;
  } iq_entry_t;
  localparam logic [31:0] INS_NOP = 32'h0;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction buffer with registered ready and single-cycle flush
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_ins,
  input  logic                     if_adel,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_ins,
  output logic                     id_adel,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  iq_entry_t mem [DEPTH];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic enq, deq, full_n;
  iq_entry_t head;
  assign enq = if_valid && if_ready && !flush;
  assign id_valid = (wptr != rptr) && !flush;
  assign deq = id_valid && id_ready;
  assign head = mem[rptr[AW-1:0]];
  assign id_pc = id_valid ? head.pc : 32'h0;
  assign id_ins = id_valid ? head.ins : INS_NOP;
  assign id_adel = id_valid && head.adel;
  assign level = wptr - rptr;
  assign wptr_n = wptr + (AW+1)'(enq);
  // a flush empties the queue by catching the read pointer up to the pre-edge write pointer
  assign rptr_n = flush ? wptr : rptr + (AW+1)'(deq);
  assign full_n = (wptr_n[AW-1:0] == rptr_n[AW-1:0]) && (wptr_n[AW] != rptr_n[AW]);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      if_ready <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      if_ready <= !full_n;
      if (enq) mem[wptr[AW-1:0]] <= '{pc: if_pc, ins: if_adel ? INS_NOP : if_ins, adel: if_adel};
    end
  end
endmodule
